// File: rtl/router_in_arbiter_if.sv
// Handshake bundle between three packet sources, the input arbiter and router_top's input port.
// The arbiter takes the slave view; sources and router stand-ins take the master view.
interface router_in_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              src_pkt_valid_0;
  logic              src_pkt_valid_1;
  logic              src_pkt_valid_2;
  logic [DATA_W-1:0] src_data_0;
  logic [DATA_W-1:0] src_data_1;
  logic [DATA_W-1:0] src_data_2;
  logic              src_ready_0;
  logic              src_ready_1;
  logic              src_ready_2;
  logic              grant_0;
  logic              grant_1;
  logic              grant_2;
  logic              rtr_busy;
  logic              rtr_pkt_valid;
  logic [DATA_W-1:0] rtr_data;
  logic              len_err;

  modport slave (
    input  src_pkt_valid_0, src_pkt_valid_1, src_pkt_valid_2,
    input  src_data_0, src_data_1, src_data_2,
    input  rtr_busy,
    output src_ready_0, src_ready_1, src_ready_2,
    output grant_0, grant_1, grant_2,
    output rtr_pkt_valid, rtr_data, len_err
  );

  modport master (
    output src_pkt_valid_0, src_pkt_valid_1, src_pkt_valid_2,
    output src_data_0, src_data_1, src_data_2,
    output rtr_busy,
    input  src_ready_0, src_ready_1, src_ready_2,
    input  grant_0, grant_1, grant_2,
    input  rtr_pkt_valid, rtr_data, len_err
  );
endinterface

// File: rtl/router_in_arbiter.sv
// Round-robin whole-packet arbiter sharing router_top's single input port among three sources.
// Define ROUTER_ARB_LEN_CHECK_EN to enable header-length checking, len_err and overlong draining.
module router_in_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clock,
  input  logic               resetn,
  router_in_arbiter_if.slave bus
);
  localparam int unsigned NSRC  = 3;
  localparam int unsigned GAP_W = 4;

`ifdef ROUTER_ARB_LEN_CHECK_EN
  localparam int unsigned LEN_W = 6;
  typedef enum logic [1:0] {IDLE, FWD, GAP, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, FWD, GAP} state_t;
`endif

  state_t            state, state_nx;
  logic [NSRC-1:0]   grant, grant_nx, req;
  logic [1:0]        rr_ptr, rr_ptr_nx, winner;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic              sel_valid, active, xfer, trunc;
  logic [DATA_W-1:0] sel_data;

  assign req = {bus.src_pkt_valid_2, bus.src_pkt_valid_1, bus.src_pkt_valid_0};

  // Request and byte of the current owner (grant is one-hot or zero)
  assign sel_valid = |(grant & req);
  assign sel_data  = ({DATA_W{grant[0]}} & bus.src_data_0)
                   | ({DATA_W{grant[1]}} & bus.src_data_1)
                   | ({DATA_W{grant[2]}} & bus.src_data_2);

`ifdef ROUTER_ARB_LEN_CHECK_EN
  assign active = (state == FWD) || (state == DRAIN);
`else
  assign active = (state == FWD);
`endif
  assign xfer = active & ~bus.rtr_busy & (|grant);

`ifdef ROUTER_ARB_LEN_CHECK_EN
  logic [LEN_W-1:0] remain;
  logic             hdr_pend, short_pkt;

  // Overlong packets are truncated: the offending byte goes out as parity
  assign trunc     = (state == FWD) & xfer & ~hdr_pend & sel_valid & (remain == '0);
  assign short_pkt = (state == FWD) & xfer & ~hdr_pend & ~sel_valid & (remain != '0);
  assign bus.len_err = trunc | short_pkt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      remain   <= '0;
      hdr_pend <= 1'b0;
    end else if (state == IDLE) begin
      hdr_pend <= 1'b1;
    end else if ((state == FWD) && xfer) begin
      if (hdr_pend) begin
        remain   <= sel_data[7:2];
        hdr_pend <= 1'b0;
      end else if (sel_valid && (remain != '0)) begin
        remain <= remain - LEN_W'(1);
      end
    end
  end
`else
  assign trunc       = 1'b0;
  assign bus.len_err = 1'b0;
`endif

  assign bus.src_ready_0   = grant[0] & active & ~bus.rtr_busy;
  assign bus.src_ready_1   = grant[1] & active & ~bus.rtr_busy;
  assign bus.src_ready_2   = grant[2] & active & ~bus.rtr_busy;
  assign bus.grant_0       = grant[0];
  assign bus.grant_1       = grant[1];
  assign bus.grant_2       = grant[2];
  assign bus.rtr_pkt_valid = (state == FWD) & sel_valid & ~trunc;
  assign bus.rtr_data      = (state == FWD) ? sel_data : '0;

  // First requester after rr_ptr in the order 0 -> 1 -> 2 -> 0
  always_comb begin
    winner = 2'd0;
    case (rr_ptr)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= 2'd2;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      rr_ptr  <= rr_ptr_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rr_ptr_nx  = rr_ptr;
    gap_cnt_nx = gap_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx  = 3'b001 << winner;
          rr_ptr_nx = winner;
          state_nx  = FWD;
        end
      end
      FWD: begin
        if (xfer && !sel_valid) begin
          grant_nx   = '0;
          gap_cnt_nx = GAP_W'(GAP_CYCLES - 1);
          state_nx   = GAP;
        end
`ifdef ROUTER_ARB_LEN_CHECK_EN
        if (trunc) state_nx = DRAIN;
`endif
      end
`ifdef ROUTER_ARB_LEN_CHECK_EN
      // Discard the rest of an overlong packet up to and including its parity byte
      DRAIN: begin
        if (xfer && !sel_valid) begin
          grant_nx   = '0;
          gap_cnt_nx = GAP_W'(GAP_CYCLES - 1);
          state_nx   = GAP;
        end
      end
`endif
      GAP: begin
        if (gap_cnt == '0) state_nx = IDLE;
        else               gap_cnt_nx = gap_cnt - GAP_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_router_in_arbiter.sv
// Bench for router_in_arbiter: queue-based packet sources, a cycle-level arbitration model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_router_in_arbiter;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP    = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_in_arbiter_if #(.DATA_W(DATA_W)) bus ();
  router_in_arbiter #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Per-source byte streams; front element is what the source currently presents
  logic [7:0] sd     [3][$];
  bit         sv     [3][$];
  logic [7:0] exp_rx [3][$];
  logic [7:0] rx     [3][$];
  int         pv_cnt [3];
  int         grant_log[$];
  int         grant_cyc[$];
  int         par_cyc[$];
  int         lenerr_cnt, lenerr_idx;
  logic       lenerr_pv;
  logic       busy_drv = 1'b0;
  bit         model_en = 1'b1;
  bit         busy_chk = 1'b0;
  logic [7:0] busy_byte;
  logic [2:0] prev_grant, cap_ready, cap_v;
  logic       cap_busy;

  // Model: mode 0 idle, 1 forwarding, 2 gap
  int m_mode, m_owner, m_rr, m_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  function automatic logic [2:0] dut_grant();
    return {bus.grant_2, bus.grant_1, bus.grant_0};
  endfunction

  function automatic logic [2:0] dut_ready();
    return {bus.src_ready_2, bus.src_ready_1, bus.src_ready_0};
  endfunction

  task automatic apply_inputs();
    logic       v [3];
    logic [7:0] d [3];
    for (int s = 0; s < 3; s++) begin
      v[s] = (sd[s].size() > 0) ? sv[s][0] : 1'b0;
      d[s] = (sd[s].size() > 0) ? sd[s][0] : 8'h00;
    end
    bus.src_pkt_valid_0 = v[0]; bus.src_data_0 = d[0];
    bus.src_pkt_valid_1 = v[1]; bus.src_data_1 = d[1];
    bus.src_pkt_valid_2 = v[2]; bus.src_data_2 = d[2];
    bus.rtr_busy = busy_drv;
  endtask

  task automatic add_pkt(input int s, input logic [7:0] hdr, input int npay);
    logic [7:0] par, b;
    par = hdr;
    sd[s].push_back(hdr); sv[s].push_back(1'b1); exp_rx[s].push_back(hdr);
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom);
      par ^= b;
      sd[s].push_back(b); sv[s].push_back(1'b1); exp_rx[s].push_back(b);
    end
    sd[s].push_back(par); sv[s].push_back(1'b0); exp_rx[s].push_back(par);
  endtask

  task automatic clear_logs();
    for (int s = 0; s < 3; s++) begin
      rx[s].delete(); exp_rx[s].delete(); pv_cnt[s] = 0;
    end
    grant_log.delete(); grant_cyc.delete(); par_cyc.delete();
    lenerr_cnt = 0; lenerr_idx = -1; lenerr_pv = 1'b0;
  endtask

  task automatic check_cycle();
    logic [2:0] g, rdy, ev, eg, er;
    logic [7:0] d [3];
    logic       ep;
    logic [7:0] ed;
    int         own;
    g   = dut_grant();
    rdy = dut_ready();
    ev  = {bus.src_pkt_valid_2, bus.src_pkt_valid_1, bus.src_pkt_valid_0};
    d[0] = bus.src_data_0; d[1] = bus.src_data_1; d[2] = bus.src_data_2;
    own = g[0] ? 0 : (g[1] ? 1 : (g[2] ? 2 : -1));
    if (model_en) begin
      eg = (m_mode == 1) ? 3'(1 << m_owner) : 3'b000;
      er = bus.rtr_busy ? 3'b000 : eg;
      ep = (m_mode == 1) ? ev[m_owner] : 1'b0;
      ed = (m_mode == 1) ? d[m_owner] : 8'h00;
      check("grant", 32'(g), 32'(eg));
      check("src_ready", 32'(rdy), 32'(er));
      check("rtr_pkt_valid", 32'(bus.rtr_pkt_valid), 32'(ep));
      check("rtr_data", 32'(bus.rtr_data), 32'(ed));
      check("len_err", 32'(bus.len_err), 32'd0);
    end
    if (busy_chk) begin
      check("busy_data_frozen", 32'(bus.rtr_data), 32'(busy_byte));
      check("busy_pkt_valid", 32'(bus.rtr_pkt_valid), 32'd1);
      check("busy_src_ready", 32'(rdy), 32'd0);
    end
    if (g != 3'b000 && prev_grant == 3'b000) begin
      grant_log.push_back(own); grant_cyc.push_back(cyc);
    end
    prev_grant = g;
    if (bus.len_err) lenerr_cnt++;
    if (rdy != 3'b000 && own >= 0) begin
      rx[own].push_back(bus.rtr_data);
      if (bus.rtr_pkt_valid) pv_cnt[own]++;
      else par_cyc.push_back(cyc);
      if (bus.len_err) begin
        lenerr_idx = rx[own].size() - 1; lenerr_pv = bus.rtr_pkt_valid;
      end
    end
    cap_ready = rdy; cap_v = ev; cap_busy = bus.rtr_busy;
  endtask

  task automatic model_advance();
    bit found;
    case (m_mode)
      0: if (cap_v != 3'b000) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++)
          if (!found && cap_v[(m_rr + k) % 3]) begin
            m_owner = (m_rr + k) % 3; found = 1'b1;
          end
        m_rr = m_owner; m_mode = 1;
      end
      1: if (!cap_busy && !cap_v[m_owner]) begin m_mode = 2; m_gap = GAP; end
      default: begin m_gap--; if (m_gap == 0) m_mode = 0; end
    endcase
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    cyc++;
    if (model_en) model_advance();
    for (int s = 0; s < 3; s++)
      if (cap_ready[s] && sd[s].size() > 0) begin
        void'(sd[s].pop_front()); void'(sv[s].pop_front());
      end
    apply_inputs();
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((sd[0].size() + sd[1].size() + sd[2].size()) != 0 && n < budget) begin
      step(); n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (GAP + 2) step();
  endtask

  task automatic check_rx(input int s);
    int bad = 0;
    check($sformatf("rx_count_src%0d", s), 32'(rx[s].size()), 32'(exp_rx[s].size()));
    for (int i = 0; i < exp_rx[s].size(); i++)
      if (i >= rx[s].size() || rx[s][i] !== exp_rx[s][i]) bad++;
    check($sformatf("rx_bytes_src%0d", s), 32'(bad), 32'd0);
  endtask

  task automatic reset_model();
    m_mode = 0; m_owner = 0; m_rr = 2; m_gap = 0; prev_grant = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    reset_model();
    clear_logs();
    apply_inputs();
    @(negedge clock);
    check("rst_grant", 32'(dut_grant()), 32'd0);
    check("rst_src_ready", 32'(dut_ready()), 32'd0);
    check("rst_pkt_valid", 32'(bus.rtr_pkt_valid), 32'd0);
    check("rst_data", 32'(bus.rtr_data), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Idle for 20 cycles
    repeat (20) step();
    check("idle_grant", 32'(dut_grant()), 32'd0);
    check("idle_pkt_valid", 32'(bus.rtr_pkt_valid), 32'd0);
    check("idle_data", 32'(bus.rtr_data), 32'd0);
    check("idle_len_err", 32'(bus.len_err), 32'd0);
    check("idle_no_grants", 32'(grant_log.size()), 32'd0);

    // Src2 alone: len 15 then len 2, back to back
    clear_logs();
    add_pkt(2, 8'h3E, 15);
    add_pkt(2, 8'h0A, 2);
    apply_inputs();
    c0 = cyc;
    run_drain(200);
    check("s2_grants", 32'(grant_log.size()), 32'd2);
    check("s2_owner", 32'(grant_log[0]), 32'd2);
    check("s2_grant_latency", 32'(grant_cyc[0] - c0), 32'd1);
    check("s2_pv_cycles", 32'(pv_cnt[2]), 32'd19);       // 16 + 3
    check("s2_gap_to_regrant", 32'(grant_cyc[1] - par_cyc[0]), 32'(GAP + 2));
    check_rx(2);

    // All three request together: expect 0, 1, 2, then 0 again
    clear_logs();
    add_pkt(0, 8'h05, 1);
    add_pkt(0, 8'h0C, 3);
    add_pkt(1, 8'h09, 2);
    add_pkt(2, 8'h02, 0);
    apply_inputs();
    run_drain(200);
    check("rr_count", 32'(grant_log.size()), 32'd4);
    check("rr_first", 32'(grant_log[0]), 32'd0);
    check("rr_second", 32'(grant_log[1]), 32'd1);
    check("rr_third", 32'(grant_log[2]), 32'd2);
    check("rr_fourth", 32'(grant_log[3]), 32'd0);
    for (int s = 0; s < 3; s++) check_rx(s);

    // Busy for 4 cycles mid-payload of a src1 packet
    clear_logs();
    add_pkt(1, 8'h21, 8);
    apply_inputs();
    n = 0;
    while (rx[1].size() < 4 && n < 100) begin step(); n++; end
    check("busy_point_reached", 32'(n < 100), 32'd1);
    busy_byte = exp_rx[1][4];
    busy_drv  = 1'b1;
    apply_inputs();
    busy_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) busy_drv = 1'b0;
      step();
    end
    busy_chk = 1'b0;
    run_drain(200);
    check("busy_pv_cycles", 32'(pv_cnt[1]), 32'd9);
    check_rx(1);

    // Asynchronous reset during byte 5 of a src1 packet
    clear_logs();
    add_pkt(1, 8'h29, 10);
    apply_inputs();
    n = 0;
    while (rx[1].size() < 5 && n < 100) begin step(); n++; end
    check("rst_point_reached", 32'(n < 100), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_grant", 32'(dut_grant()), 32'd0);
    check("arst_src_ready", 32'(dut_ready()), 32'd0);
    check("arst_pkt_valid", 32'(bus.rtr_pkt_valid), 32'd0);
    check("arst_data", 32'(bus.rtr_data), 32'd0);
    check("arst_len_err", 32'(bus.len_err), 32'd0);
    for (int s = 0; s < 3; s++) begin sd[s].delete(); sv[s].delete(); end
    reset_model();
    clear_logs();
    apply_inputs();
    @(posedge clock); #1;
    resetn = 1'b1;
    add_pkt(0, 8'h05, 1);
    add_pkt(1, 8'h09, 2);
    apply_inputs();
    run_drain(200);
    check("post_rst_first", 32'(grant_log[0]), 32'd0);
    check("post_rst_second", 32'(grant_log[1]), 32'd1);
    check_rx(0);
    check_rx(1);

    // Header says len 4 but six payload bytes follow
    clear_logs();
`ifdef ROUTER_ARB_LEN_CHECK_EN
    model_en = 1'b0;
`endif
    add_pkt(0, 8'h11, 6);
    apply_inputs();
    run_drain(200);
`ifdef ROUTER_ARB_LEN_CHECK_EN
    check("len_err_pulses", 32'(lenerr_cnt), 32'd1);
    check("len_err_on_5th_payload", 32'(lenerr_idx), 32'd5);
    check("len_err_pkt_valid", 32'(lenerr_pv), 32'd0);
    check("len_pv_cycles", 32'(pv_cnt[0]), 32'd5);
`else
    check("len_err_never", 32'(lenerr_cnt), 32'd0);
    check("len_pv_cycles", 32'(pv_cnt[0]), 32'd7);
    check_rx(0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
